// File: rtl/bp_be_sys_cmd_pipe.sv
// CSR command pipeline with per-stage kill, plus a queued page-table-walk request
// path fed by final-stage TLB misses, a single tracked walk and fault reporting.
module bp_be_sys_cmd_pipe #(
    parameter int vaddr_width_p  = 39,
    parameter int dword_width_p  = 64,
    parameter int csr_op_width_p = 5,
    parameter int stages_p       = 2,
    parameter int miss_els_p     = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cmd_v_i,
    input  logic [csr_op_width_p-1:0] cmd_op_i,
    input  logic [11:0]               cmd_addr_i,
    input  logic [dword_width_p-1:0]  cmd_data_i,
    input  logic                      cmd_is_store_i,
    input  logic [stages_p-1:0]       kill_i,
    input  logic                      flush_i,
    input  logic                      itlb_miss_i,
    input  logic                      dtlb_miss_i,
    input  logic [vaddr_width_p-1:0]  exc_pc_i,
    input  logic [vaddr_width_p-1:0]  exc_vaddr_i,
    output logic                      csr_v_o,
    output logic [csr_op_width_p-1:0] csr_op_o,
    output logic [11:0]               csr_addr_o,
    output logic [dword_width_p-1:0]  csr_data_o,
    output logic                      miss_v_o,
    input  logic                      miss_ready_i,
    output logic [1:0]                miss_type_o,
    output logic [vaddr_width_p-1:0]  miss_pc_o,
    output logic [vaddr_width_p-1:0]  miss_vaddr_o,
    input  logic                      fill_v_i,
    input  logic                      fill_fault_i,
    output logic                      fault_v_o,
    output logic [1:0]                fault_type_o,
    output logic [vaddr_width_p-1:0]  fault_pc_o,
    output logic [vaddr_width_p-1:0]  fault_vaddr_o,
    output logic                      replay_o,
    output logic                      walk_busy_o
);

    localparam int last = stages_p - 1;
    localparam int ptr_w = $clog2(miss_els_p);
    localparam logic [ptr_w:0] ptr_one = (ptr_w + 1)'(1);

    // Stage pipeline: index k holds the occupant of stage k+1
    logic                      v_p     [stages_p];
    logic [csr_op_width_p-1:0] op_p    [stages_p];
    logic [11:0]               addr_p  [stages_p];
    logic [dword_width_p-1:0]  data_p  [stages_p];
    logic                      store_p [stages_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < stages_p; k++) v_p[k] <= 1'b0;
        end else if (flush_i) begin
            for (int k = 0; k < stages_p; k++) v_p[k] <= 1'b0;
        end else begin
            v_p[0] <= cmd_v_i;
            for (int k = 1; k < stages_p; k++) v_p[k] <= v_p[k-1] & ~kill_i[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        op_p[0]    <= cmd_op_i;
        addr_p[0]  <= cmd_addr_i;
        data_p[0]  <= cmd_data_i;
        store_p[0] <= cmd_is_store_i;
        for (int k = 1; k < stages_p; k++) begin
            op_p[k]    <= op_p[k-1];
            addr_p[k]  <= addr_p[k-1];
            data_p[k]  <= data_p[k-1];
            store_p[k] <= store_p[k-1];
        end
    end

    assign csr_v_o    = v_p[last] & ~kill_i[last];
    assign csr_op_o   = op_p[last];
    assign csr_addr_o = addr_p[last];
    assign csr_data_o = data_p[last];

    // Miss FIFO with extra-MSB pointers
    logic [1:0]               mem_type  [miss_els_p];
    logic [vaddr_width_p-1:0] mem_pc    [miss_els_p];
    logic [vaddr_width_p-1:0] mem_vaddr [miss_els_p];
    logic [ptr_w:0]           wr_ptr, rd_ptr;
    logic                     empty, full, busy;
    logic                     enq_req, enq, deq;
    logic [1:0]               enq_type;
    logic [vaddr_width_p-1:0] enq_vaddr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) && (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);

    assign enq_req   = (itlb_miss_i | dtlb_miss_i) & ~kill_i[last] & ~flush_i;
    assign deq       = miss_v_o & miss_ready_i;
    assign enq       = enq_req & (~full | deq);
    assign replay_o  = enq_req & full & ~deq;
    assign enq_type  = itlb_miss_i ? 2'd0 : (store_p[last] ? 2'd2 : 2'd1);
    assign enq_vaddr = itlb_miss_i ? exc_pc_i : exc_vaddr_i;

    assign miss_v_o     = ~empty & ~busy;
    assign miss_type_o  = mem_type[rd_ptr[ptr_w-1:0]];
    assign miss_pc_o    = mem_pc[rd_ptr[ptr_w-1:0]];
    assign miss_vaddr_o = mem_vaddr[rd_ptr[ptr_w-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_one;
            if (deq) rd_ptr <= rd_ptr + ptr_one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_type[wr_ptr[ptr_w-1:0]]  <= enq_type;
            mem_pc[wr_ptr[ptr_w-1:0]]    <= exc_pc_i;
            mem_vaddr[wr_ptr[ptr_w-1:0]] <= enq_vaddr;
        end
    end

    // Walk in flight; survives flush, dropped only by reset
    logic [1:0]               walk_type;
    logic [vaddr_width_p-1:0] walk_pc, walk_vaddr;

    always_ff @(posedge clk_i) begin
        if (deq) begin
            walk_type  <= miss_type_o;
            walk_pc    <= miss_pc_o;
            walk_vaddr <= miss_vaddr_o;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy          <= 1'b0;
            fault_v_o     <= 1'b0;
            fault_type_o  <= '0;
            fault_pc_o    <= '0;
            fault_vaddr_o <= '0;
        end else begin
            if (deq)
                busy <= 1'b1;
            else if (fill_v_i)
                busy <= 1'b0;
            fault_v_o <= fill_v_i & busy & fill_fault_i;
            if (fill_v_i & busy & fill_fault_i) begin
                fault_type_o  <= walk_type;
                fault_pc_o    <= walk_pc;
                fault_vaddr_o <= walk_vaddr;
            end
        end
    end

    assign walk_busy_o = busy;

endmodule

// File: tb/tb_bp_be_sys_cmd_pipe.sv
// Bench for bp_be_sys_cmd_pipe: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_bp_be_sys_cmd_pipe;

    localparam int VW = 39;
    localparam int DW = 64;
    localparam int OW = 5;
    localparam int ST = 3;
    localparam int ME = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_v, cmd_is_store, flush, itlb, dtlb, ready, fill_v, fill_fault;
    logic [OW-1:0] cmd_op;
    logic [11:0]   cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [ST-1:0] kill;
    logic [VW-1:0] exc_pc, exc_vaddr;
    logic          csr_v, miss_v, fault_v, replay, walk_busy;
    logic [OW-1:0] csr_op;
    logic [11:0]   csr_addr;
    logic [DW-1:0] csr_data;
    logic [1:0]    miss_type, fault_type;
    logic [VW-1:0] miss_pc, miss_vaddr, fault_pc, fault_vaddr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_be_sys_cmd_pipe #(
        .vaddr_width_p(VW), .dword_width_p(DW), .csr_op_width_p(OW),
        .stages_p(ST), .miss_els_p(ME)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .cmd_is_store_i(cmd_is_store), .kill_i(kill), .flush_i(flush),
        .itlb_miss_i(itlb), .dtlb_miss_i(dtlb), .exc_pc_i(exc_pc), .exc_vaddr_i(exc_vaddr),
        .csr_v_o(csr_v), .csr_op_o(csr_op), .csr_addr_o(csr_addr), .csr_data_o(csr_data),
        .miss_v_o(miss_v), .miss_ready_i(ready), .miss_type_o(miss_type),
        .miss_pc_o(miss_pc), .miss_vaddr_o(miss_vaddr),
        .fill_v_i(fill_v), .fill_fault_i(fill_fault),
        .fault_v_o(fault_v), .fault_type_o(fault_type),
        .fault_pc_o(fault_pc), .fault_vaddr_o(fault_vaddr),
        .replay_o(replay), .walk_busy_o(walk_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_v = 0; cmd_is_store = 0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        kill = '0; flush = 0; itlb = 0; dtlb = 0; ready = 0;
        fill_v = 0; fill_fault = 0; exc_pc = '0; exc_vaddr = '0;
    endtask

    // Reference model: input history for the command path, a queue for the miss path
    typedef struct packed {
        logic          v;
        logic [OW-1:0] op;
        logic [11:0]   addr;
        logic [DW-1:0] data;
        logic          st;
        logic [ST-1:0] kill;
        logic          fl;
    } hist_t;

    typedef struct packed {
        logic [1:0]    t;
        logic [VW-1:0] pc;
        logic [VW-1:0] va;
    } ment_t;

    hist_t h [4];
    hist_t m_cur, m_s3, m_s2, m_s1;
    ment_t mq[$];
    ment_t m_walk, m_flt, m_e;
    logic  m_busy = 1'b0, m_fpend = 1'b0;
    logic  m_csr, m_mv, m_req, m_deq, m_full, m_rep;
    int    m_n = 0;

    initial begin
        for (int i = 0; i < 4; i++) h[i] = '0;
        m_flt = '0;
        m_walk = '0;
    end

    always @(negedge clk) begin
        m_cur = '{v: cmd_v, op: cmd_op, addr: cmd_addr, data: cmd_data, st: cmd_is_store,
                  kill: kill, fl: flush};
        if (!reset_n) begin
            chk("rst_csr_v", 64'(csr_v), 64'(0));
            chk("rst_miss_v", 64'(miss_v), 64'(0));
            chk("rst_fault_v", 64'(fault_v), 64'(0));
            chk("rst_replay", 64'(replay), 64'(0));
            chk("rst_busy", 64'(walk_busy), 64'(0));
            chk("rst_fault_pc", 64'(fault_pc), 64'(0));
            mq.delete();
            m_busy = 0; m_fpend = 0; m_flt = '0;
            for (int i = 0; i < 4; i++) h[i].v = 1'b0;
            m_cur.v = 1'b0;
            h[m_n % 4] = m_cur;
        end else begin
            h[m_n % 4] = m_cur;
            m_s3 = h[(m_n + 1) % 4];
            m_s2 = h[(m_n + 2) % 4];
            m_s1 = h[(m_n + 3) % 4];
            m_csr = m_s3.v & ~m_s2.kill[0] & ~m_s1.kill[1] & ~m_cur.kill[2]
                    & ~m_s3.fl & ~m_s2.fl & ~m_s1.fl;
            chk("csr_v", 64'(csr_v), 64'(m_csr));
            if (m_csr) begin
                chk("csr_op", 64'(csr_op), 64'(m_s3.op));
                chk("csr_addr", 64'(csr_addr), 64'(m_s3.addr));
                chk("csr_data", csr_data, m_s3.data);
            end
            m_mv = (mq.size() != 0) && !m_busy;
            chk("miss_v", 64'(miss_v), 64'(m_mv));
            if (m_mv) begin
                chk("miss_type", 64'(miss_type), 64'(mq[0].t));
                chk("miss_pc", 64'(miss_pc), 64'(mq[0].pc));
                chk("miss_vaddr", 64'(miss_vaddr), 64'(mq[0].va));
            end
            m_req  = (itlb | dtlb) & ~kill[2] & ~flush;
            m_deq  = m_mv & ready;
            m_full = (mq.size() == ME);
            m_rep  = m_req & m_full & ~m_deq;
            chk("replay", 64'(replay), 64'(m_rep));
            chk("fault_v", 64'(fault_v), 64'(m_fpend));
            chk("fault_type", 64'(fault_type), 64'(m_flt.t));
            chk("fault_pc", 64'(fault_pc), 64'(m_flt.pc));
            chk("fault_vaddr", 64'(fault_vaddr), 64'(m_flt.va));
            chk("walk_busy", 64'(walk_busy), 64'(m_busy));

            m_fpend = 1'b0;
            if (m_deq) begin
                m_walk = mq.pop_front();
                m_busy = 1'b1;
            end else if (fill_v && m_busy) begin
                m_busy = 1'b0;
                if (fill_fault) begin
                    m_fpend = 1'b1;
                    m_flt = m_walk;
                end
            end
            if (m_req && (!m_full || m_deq)) begin
                m_e.t  = itlb ? 2'd0 : (m_s3.st ? 2'd2 : 2'd1);
                m_e.pc = exc_pc;
                m_e.va = itlb ? exc_pc : exc_vaddr;
                mq.push_back(m_e);
            end
            if (flush) mq.delete();
        end
        m_n++;
    end

    logic [63:0] r;

    initial begin
        idle();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_csr_v", 64'(csr_v), 64'(0));
        chk("reset_miss_v", 64'(miss_v), 64'(0));
        chk("reset_fault_v", 64'(fault_v), 64'(0));
        chk("reset_fault_type", 64'(fault_type), 64'(0));
        chk("reset_busy", 64'(walk_busy), 64'(0));
        tk(); reset_n = 1;
        tk();

        // Basic latency: visible exactly three cycles after issue
        cmd_v = 1; cmd_op = 5'd5; cmd_addr = 12'h300; cmd_data = 64'hA5;
        tk(); cmd_v = 0;
        #1 chk("lat_t1", 64'(csr_v), 64'(0));
        tk(); #1 chk("lat_t2", 64'(csr_v), 64'(0));
        tk(); #1 chk("lat_t3_v", 64'(csr_v), 64'(1));
        chk("lat_op", 64'(csr_op), 64'(5));
        chk("lat_addr", 64'(csr_addr), 64'h300);
        chk("lat_data", csr_data, 64'hA5);
        tk(); #1 chk("lat_t4", 64'(csr_v), 64'(0));

        // Middle-stage kill
        cmd_v = 1; tk(); cmd_v = 0;
        tk(); kill = 3'b010;
        tk(); kill = 3'b000;
        #1 chk("kill1_v", 64'(csr_v), 64'(0));

        // Final-stage kill gates output and the miss
        cmd_v = 1; tk(); cmd_v = 0; tk(); tk();
        kill = 3'b100; dtlb = 1; exc_vaddr = 39'h1000;
        #1 chk("kill2_v", 64'(csr_v), 64'(0));
        chk("kill2_replay", 64'(replay), 64'(0));
        tk(); kill = 3'b000; dtlb = 0;
        #1 chk("kill2_noenq", 64'(miss_v), 64'(0));

        // Miss typing: store data miss, then itlb priority
        cmd_is_store = 1; tk(); cmd_is_store = 0; tk(); tk();
        dtlb = 1; exc_vaddr = 39'h1000; exc_pc = 39'h80;
        tk(); dtlb = 0;
        #1 chk("st_miss_v", 64'(miss_v), 64'(1));
        chk("st_miss_type", 64'(miss_type), 64'(2));
        chk("st_miss_vaddr", 64'(miss_vaddr), 64'h1000);
        chk("st_miss_pc", 64'(miss_pc), 64'h80);
        ready = 1; tk(); ready = 0;
        #1 chk("st_busy", 64'(walk_busy), 64'(1));
        chk("st_miss_v_busy", 64'(miss_v), 64'(0));
        fill_v = 1; tk(); fill_v = 0;
        #1 chk("st_fill_busy", 64'(walk_busy), 64'(0));
        chk("st_fill_nofault", 64'(fault_v), 64'(0));
        itlb = 1; dtlb = 1; exc_pc = 39'h80; exc_vaddr = 39'h1000;
        tk(); itlb = 0; dtlb = 0;
        #1 chk("i_miss_type", 64'(miss_type), 64'(0));
        chk("i_miss_vaddr", 64'(miss_vaddr), 64'h80);

        // FIFO full while a walk is busy
        ready = 1; tk(); ready = 0;
        #1 chk("full_busy", 64'(walk_busy), 64'(1));
        dtlb = 1; exc_pc = 39'h40; exc_vaddr = 39'h2000; tk();
        exc_vaddr = 39'h2100; tk();
        exc_vaddr = 39'h2180;
        #1 chk("full_replay", 64'(replay), 64'(1));
        tk(); dtlb = 0;
        fill_v = 1; tk(); fill_v = 0;
        #1 chk("full_head_v", 64'(miss_v), 64'(1));
        chk("full_head_vaddr", 64'(miss_vaddr), 64'h2000);
        chk("full_head_type", 64'(miss_type), 64'(1));
        ready = 1; dtlb = 1; exc_vaddr = 39'h2200;
        #1 chk("pop_push_replay", 64'(replay), 64'(0));
        tk(); ready = 0; dtlb = 0;
        #1 chk("pop_push_busy", 64'(walk_busy), 64'(1));

        // Fault reporting and idle fill
        fill_v = 1; fill_fault = 1; tk(); fill_v = 0; fill_fault = 0;
        #1 chk("flt_v", 64'(fault_v), 64'(1));
        chk("flt_type", 64'(fault_type), 64'(1));
        chk("flt_pc", 64'(fault_pc), 64'h40);
        chk("flt_vaddr", 64'(fault_vaddr), 64'h2000);
        chk("flt_busy", 64'(walk_busy), 64'(0));
        tk(); #1 chk("flt_pulse", 64'(fault_v), 64'(0));
        chk("hold_vaddr", 64'(miss_vaddr), 64'h2100);
        fill_v = 1; fill_fault = 1; tk(); fill_v = 0; fill_fault = 0;
        #1 chk("idle_fill_fault", 64'(fault_v), 64'(0));
        chk("idle_fill_busy", 64'(walk_busy), 64'(0));

        // Flush with full FIFO and a walk in flight
        ready = 1; tk(); ready = 0;
        dtlb = 1; exc_vaddr = 39'h2300; tk(); dtlb = 0;
        cmd_v = 1; tk(); cmd_v = 0;
        flush = 1; dtlb = 1; exc_vaddr = 39'h2400;
        #1 chk("flush_replay", 64'(replay), 64'(0));
        tk(); flush = 0; dtlb = 0;
        fill_v = 1; fill_fault = 1; tk(); fill_v = 0; fill_fault = 0;
        #1 chk("flush_fault_v", 64'(fault_v), 64'(1));
        chk("flush_fault_vaddr", 64'(fault_vaddr), 64'h2100);
        chk("flush_empty", 64'(miss_v), 64'(0));
        chk("flush_csr_v", 64'(csr_v), 64'(0));

        // Asynchronous reset mid-walk
        dtlb = 1; exc_vaddr = 39'h2500; tk(); dtlb = 0;
        ready = 1; tk(); ready = 0;
        dtlb = 1; exc_vaddr = 39'h2600; tk(); dtlb = 0;
        cmd_v = 1; tk(); cmd_v = 0; tk();
        #1 chk("pre_rst_busy", 64'(walk_busy), 64'(1));
        reset_n = 0;
        #1 chk("mid_rst_busy", 64'(walk_busy), 64'(0));
        chk("mid_rst_fault_vaddr", 64'(fault_vaddr), 64'(0));
        chk("mid_rst_miss_v", 64'(miss_v), 64'(0));
        chk("mid_rst_csr_v", 64'(csr_v), 64'(0));
        tk(); tk(); reset_n = 1;
        tk();
        fill_v = 1; fill_fault = 1; tk(); fill_v = 0; fill_fault = 0;
        #1 chk("post_rst_nofault", 64'(fault_v), 64'(0));
        chk("post_rst_empty", 64'(miss_v), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tk();
            cmd_v = ($urandom % 2) == 0;
            cmd_op = 5'($urandom);
            cmd_addr = 12'($urandom);
            cmd_data = {$urandom(), $urandom()};
            cmd_is_store = ($urandom % 2) == 0;
            for (int j = 0; j < ST; j++) kill[j] = ($urandom % 8) == 0;
            flush = ($urandom % 32) == 0;
            itlb = ($urandom % 8) == 0;
            dtlb = ($urandom % 5) == 0;
            r = {$urandom(), $urandom()}; exc_pc = r[VW-1:0];
            r = {$urandom(), $urandom()}; exc_vaddr = r[VW-1:0];
            ready = ($urandom % 3) != 0;
            fill_v = ($urandom % 4) == 0;
            fill_fault = ($urandom % 2) == 0;
        end
        idle();
        repeat (5) tk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
